alu32_op_sequencer: RTL and testbench

//   Command-side feeder for the 32-bit gate-level ALU. Accepts ALU commands (op, operands,

---
 rtl/alu32_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu32_op_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_op_sequencer.sv
// alu32_op_sequencer: command FIFO in front of a gate-level ALU. Each command is
// presented on registered ALU inputs, held for SETTLE cycles, then the ALU result
// is captured and returned over a valid/ready response handshake.
module alu32_op_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETTLE     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [WIDTH-1:0]              cmd_a,
  input  logic [WIDTH-1:0]              cmd_b,
  input  logic                          cmd_ci,
  output logic [WIDTH-1:0]              alu_in1,
  output logic [WIDTH-1:0]              alu_in2,
  output logic                          alu_ci,
  output logic [2:0]                    alu_a,
  input  logic [WIDTH-1:0]              alu_out,
  input  logic                          alu_co,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_result,
  output logic                          rsp_co,
  output logic                          rsp_zero,
  output logic [2:0]                    rsp_op,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RESP} state_t;

  cmd_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_alu_in1;
  logic [WIDTH-1:0] r_alu_in2;
  logic            r_alu_ci;
  logic [2:0]      r_alu_a;
  logic            r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic            r_rsp_co;
  logic            r_rsp_zero;
  logic [2:0]      r_rsp_op;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  cmd_t            w_head;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // cmd_ready depends only on registered occupancy, so a same-cycle pop never frees a full FIFO
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = !w_empty && ((r_state == ST_IDLE) ||
                                ((r_state == ST_RESP) && rsp_ready));
  assign w_head  = r_mem[r_rd_ptr];

  // FIFO storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, ci: cmd_ci};
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer FSM: load ALU inputs, wait for settle, capture and hand back the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_ci     <= 1'b0;
      r_alu_a      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_co     <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_op     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_alu_in1 <= w_head.a;
            r_alu_in2 <= w_head.b;
            r_alu_ci  <= w_head.ci;
            r_alu_a   <= w_head.op;
            r_cnt     <= CW'(SETTLE - 1);
            r_state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_rsp_result <= alu_out;
            r_rsp_co     <= alu_co;
            r_rsp_zero   <= (alu_out == '0);
            r_rsp_op     <= r_alu_a;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            // back-to-back: next command loads on the same edge the response is taken
            if (w_pop) begin
              r_alu_in1 <= w_head.a;
              r_alu_in2 <= w_head.b;
              r_alu_ci  <= w_head.ci;
              r_alu_a   <= w_head.op;
              r_cnt     <= CW'(SETTLE - 1);
              r_state   <= ST_DRIVE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !w_full;
  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_ci     = r_alu_ci;
  assign alu_a      = r_alu_a;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_co     = r_rsp_co;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_op     = r_rsp_op;
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Bench for alu32_op_sequencer: directed vectors, multi-cycle corner sequences and
// a randomized run checked against an in-order queue of issued commands.
module tb_alu32_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_ci;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_ci;
  logic [2:0]  alu_a;
  logic [31:0] alu_out;
  logic        alu_co;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_co;
  logic        rsp_zero;
  logic [2:0]  rsp_op;
  logic        busy;
  logic [2:0]  fifo_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
  } cmd_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] res;
    logic        co;
    logic        zero;
  } vec_t;

  cmd_t exp_q[$];

  alu32_op_sequencer #(.WIDTH(32), .FIFO_DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ci(alu_ci), .alu_a(alu_a),
    .alu_out(alu_out), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_co(rsp_co), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic ci);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~a};
      3'd4:    return {1'b0, a} + {1'b0, b} + {32'd0, ci};
      default: return '0;
    endcase
  endfunction

  // stand-in for the gate-level ALU
  assign {alu_co, alu_out} = alu_model(alu_a, alu_in1, alu_in2, alu_ci);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // call with time at #1 after a rising edge
  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ci);
    int unsigned w = 0;
    cmd_t c;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_ci = ci; cmd_valid = 1'b1;
    while (!cmd_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!cmd_ready) begin
      fail_msg("push_timeout");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    c.op = op; c.a = a; c.b = b; c.ci = ci;
    exp_q.push_back(c);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int unsigned w = 0;
    while ((exp_q.size() != 0 || busy) && w < 500) begin
      @(posedge clk); #1; w++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  // response scoreboard: a handshake seen at the falling edge completes at the next rise
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic        prev_co;
  logic        prev_zero;
  logic [2:0]  prev_op;
  cmd_t        mon_e;
  logic [32:0] mon_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(rsp_valid), 64'd1);
        chk("stall_result", 64'(rsp_result), 64'(prev_res));
        chk("stall_co", 64'(rsp_co), 64'(prev_co));
        chk("stall_zero", 64'(rsp_zero), 64'(prev_zero));
        chk("stall_op", 64'(rsp_op), 64'(prev_op));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got=%0h want=none", rsp_result);
        end else begin
          mon_e = exp_q.pop_front();
          mon_m = alu_model(mon_e.op, mon_e.a, mon_e.b, mon_e.ci);
          chk("sb_result", 64'(rsp_result), 64'(mon_m[31:0]));
          chk("sb_co", 64'(rsp_co), 64'(mon_m[32]));
          chk("sb_zero", 64'(rsp_zero), 64'(mon_m[31:0] == 32'd0));
          chk("sb_op", 64'(rsp_op), 64'(mon_e.op));
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_res   = rsp_result;
      prev_co    = rsp_co;
      prev_zero  = rsp_zero;
      prev_op    = rsp_op;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  vec_t        vt[8];
  int unsigned lat;
  int unsigned nv;
  int unsigned t0, t1;
  logic [31:0] r0, r1;
  int unsigned seen;
  bit          done;

  initial begin
    vt[0] = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[1] = '{3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0};
    vt[2] = '{3'd2, 32'h12345678, 32'hFFFFFFFF, 1'b1, 32'hEDCBA987, 1'b0, 1'b0};
    vt[3] = '{3'd1, 32'h0F0F0000, 32'h000000F0, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0};
    vt[4] = '{3'd3, 32'h00000000, 32'h12345678, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[5] = '{3'd4, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0};
    vt[6] = '{3'd4, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, 1'b0};
    vt[7] = '{3'd0, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h00000000, 1'b0, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_ci = 1'b0;

    // reset state
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu", {alu_in1, alu_in2}, 64'd0);
    chk("rst_alu_ctl", 64'({alu_ci, alu_a}), 64'd0);
    chk("rst_rsp", 64'({rsp_result, rsp_co, rsp_zero, rsp_op}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // directed vectors, one at a time from idle
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vt[i].op, vt[i].a, vt[i].b, vt[i].ci);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      chk("vec_latency", 64'(lat), 64'd3);
      chk("vec_result", 64'(rsp_result), 64'(vt[i].res));
      chk("vec_co", 64'(rsp_co), 64'(vt[i].co));
      chk("vec_zero", 64'(rsp_zero), 64'(vt[i].zero));
      chk("vec_op", 64'(rsp_op), 64'(vt[i].op));
      @(posedge clk); #1;
      chk("vec_valid_drop", 64'(rsp_valid), 64'd0);
      repeat (2) @(posedge clk);
      #1;
    end

    // back-to-back pair: in order, SETTLE+1 cycles apart
    push(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    push(3'd2, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    nv = 0; t0 = 0; t1 = 0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        if (nv == 0) begin t0 = c; r0 = rsp_result; end
        else if (nv == 1) begin t1 = c; r1 = rsp_result; end
        nv++;
      end
    end
    chk("b2b_count", 64'(nv), 64'd2);
    chk("b2b_first", 64'(r0), 64'hF000F000);
    chk("b2b_second", 64'(r1), 64'hEDCBA987);
    chk("b2b_spacing", 64'(t1 - t0), 64'd3);

    // stalled consumer fills the FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(3'(i), 32'h11111111 * (i + 1), 32'h0F0F0F0F + i, i[0]);
    end
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_ready", 64'(cmd_ready), 64'd0);
    chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("full_busy", 64'(busy), 64'd1);
    cmd_op = 3'd4; cmd_a = 32'hDEADBEEF; cmd_b = 32'h21524111; cmd_ci = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_count", 64'(fifo_count), 64'd4);
      chk("stall_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    push(3'd4, 32'hDEADBEEF, 32'h21524111, 1'b0);
    drain("full_drain");

    // reset while a command is settling with two more queued
    push(3'd4, 32'h00000005, 32'h00000007, 1'b0);
    push(3'd1, 32'h00000100, 32'h00000001, 1'b0);
    push(3'd2, 32'h0000FFFF, 32'h000000FF, 1'b1);
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_alu", {alu_in1, alu_in2}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("post_rst_no_rsp", 64'(seen), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // randomized traffic with a randomly stalling consumer
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [2:0]  op;
          logic [31:0] a, b;
          logic        ci;
          op = 3'($urandom_range(0, 7));
          a  = $urandom;
          b  = $urandom;
          ci = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 4) == 0) begin
            b  = ~a + 32'd1;
            ci = 1'b0;
          end
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          push(op, a, b, ci);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain("rand_drain");
    chk("rand_count", 64'(fifo_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
